// File: rtl/bg_block_scheduler.sv
// Background block traffic sequencer: saves the dirty 16-pixel block and loads the next one
// between the backend's single-line BG cache and VRAM, pausing the pixel pipeline meanwhile.
module bg_block_scheduler (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_startPrimitive,
   input  logic         i_blockDone,
   input  logic         i_endPrimitive,
   input  logic         i_needBGRead,
   input  logic [14:0]  i_loadAdr,
   input  logic [14:0]  i_saveAdr,
   input  logic [255:0] i_saveData,
   input  logic [15:0]  i_saveMask,
   output logic         o_pausePipeline,
   output logic         o_flushClearMask,
   output logic         o_memReq,
   output logic         o_memWrite,
   output logic [14:0]  o_memAdr,
   output logic [15:0]  o_memMask,
   output logic [255:0] o_memWriteData,
   input  logic         i_memAck,
   input  logic         i_memReadValid,
   input  logic [255:0] i_memReadData,
   output logic         o_importBGBlockSingleClock,
   output logic [255:0] o_importedBGBlock,
   output logic         o_busy,
   output logic         o_error
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SAVE_REQ  = 3'd1;
   localparam logic [2:0] LOAD_REQ  = 3'd2;
   localparam logic [2:0] LOAD_WAIT = 3'd3;
   localparam logic [2:0] IMPORT    = 3'd4;
   localparam logic [2:0] FLUSH     = 3'd5;

   logic [2:0]   state;
   logic [2:0]   nextState;
   logic [14:0]  saveAdr;
   logic [14:0]  loadAdr;
   logic [255:0] saveData;
   logic [15:0]  saveMask;
   logic         needLatched;
   logic         endLatched;
   logic         isIdle;
   logic         anyTrigger;
   logic         leaveIdle;
   logic         readAccept;
   logic         errorSet;

   // Next-state selection; triggers are only honoured in IDLE with end > done > start priority.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (i_endPrimitive) begin
               nextState = (|i_saveMask) ? SAVE_REQ : FLUSH;
            end else if (i_blockDone) begin
               if (|i_saveMask) begin
                  nextState = SAVE_REQ;
               end else if (i_needBGRead) begin
                  nextState = LOAD_REQ;
               end
            end else if (i_startPrimitive) begin
               if (i_needBGRead) begin
                  nextState = LOAD_REQ;
               end
            end
         end
         SAVE_REQ: begin
            if (i_memAck) begin
               if (endLatched) begin
                  nextState = FLUSH;
               end else if (needLatched) begin
                  nextState = LOAD_REQ;
               end else begin
                  nextState = IDLE;
               end
            end
         end
         LOAD_REQ: begin
            if (i_memAck) begin
               nextState = i_memReadValid ? IMPORT : LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            if (i_memReadValid) begin
               nextState = IMPORT;
            end
         end
         IMPORT:  nextState = IDLE;
         FLUSH:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Read data is accepted in LOAD_WAIT, or when it arrives together with the load ack.
   always_comb begin
      isIdle     = (state == IDLE);
      anyTrigger = i_startPrimitive | i_blockDone | i_endPrimitive;
      leaveIdle  = isIdle & (nextState != IDLE);
      readAccept = i_memReadValid &
                   ((state == LOAD_WAIT) | ((state == LOAD_REQ) & i_memAck));
      errorSet   = (anyTrigger & ~isIdle) |
                   (i_memReadValid & ~readAccept) |
                   (i_memAck & ~o_memReq);
   end

   // State register and the block context captured alongside each trigger.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         saveAdr     <= '0;
         loadAdr     <= '0;
         saveData    <= '0;
         saveMask    <= '0;
         needLatched <= 1'b0;
         endLatched  <= 1'b0;
      end else begin
         state <= nextState;
         if (isIdle && anyTrigger) begin
            needLatched <= i_needBGRead;
            endLatched  <= i_endPrimitive;
            if (i_endPrimitive || i_blockDone) begin
               saveAdr  <= i_saveAdr;
               saveData <= i_saveData;
               saveMask <= i_saveMask;
            end
            if (!i_endPrimitive) begin
               loadAdr <= i_loadAdr;
            end
         end
      end
   end

   // Imported block and the sticky protocol-violation flag.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         o_importedBGBlock <= '0;
         o_error           <= 1'b0;
      end else begin
         if (readAccept) begin
            o_importedBGBlock <= i_memReadData;
         end
         if (errorSet) begin
            o_error <= 1'b1;
         end
      end
   end

   // Command fields come straight from the state and captured registers, so they hold until ack.
   always_comb begin
      o_memReq                   = (state == SAVE_REQ) | (state == LOAD_REQ);
      o_memWrite                 = (state == SAVE_REQ);
      o_memAdr                   = '0;
      o_memMask                  = '0;
      o_memWriteData             = '0;
      if (state == SAVE_REQ) begin
         o_memAdr       = saveAdr;
         o_memMask      = saveMask;
         o_memWriteData = saveData;
      end else if (state == LOAD_REQ) begin
         o_memAdr = loadAdr;
      end
      o_importBGBlockSingleClock = (state == IMPORT);
      o_flushClearMask           = (state == FLUSH);
      o_busy                     = ~isIdle;
      o_pausePipeline            = ~i_rst & (~isIdle | leaveIdle);
   end

endmodule

// File: tb/tb_bg_block_scheduler.sv
// Testbench for bg_block_scheduler: table vectors, hand-written corner sequences and
// randomized scenarios checked against an arithmetic model of the transaction rules.
module tb_bg_block_scheduler;

   logic         clk = 1'b0;
   logic         i_rst;
   logic         i_startPrimitive;
   logic         i_blockDone;
   logic         i_endPrimitive;
   logic         i_needBGRead;
   logic [14:0]  i_loadAdr;
   logic [14:0]  i_saveAdr;
   logic [255:0] i_saveData;
   logic [15:0]  i_saveMask;
   logic         o_pausePipeline;
   logic         o_flushClearMask;
   logic         o_memReq;
   logic         o_memWrite;
   logic [14:0]  o_memAdr;
   logic [15:0]  o_memMask;
   logic [255:0] o_memWriteData;
   logic         i_memAck;
   logic         i_memReadValid;
   logic [255:0] i_memReadData;
   logic         o_importBGBlockSingleClock;
   logic [255:0] o_importedBGBlock;
   logic         o_busy;
   logic         o_error;

   int total = 0;
   int bad   = 0;

   // kind: 0 start, 1 block done, 2 end, 3 block done together with end
   typedef struct {
      int          kind;
      logic        need;
      logic [15:0] mask;
      logic [14:0] saveAdr;
      logic [14:0] loadAdr;
      int          ackDelay;
      int          readDelay;
      int          expWrites;
      int          expLoads;
      int          expImports;
      int          expFlushes;
      int          expPause;
   } VectorRec;

   always #5 clk = ~clk;

   bg_block_scheduler dut (
      .clk                        (clk),
      .i_rst                      (i_rst),
      .i_startPrimitive           (i_startPrimitive),
      .i_blockDone                (i_blockDone),
      .i_endPrimitive             (i_endPrimitive),
      .i_needBGRead               (i_needBGRead),
      .i_loadAdr                  (i_loadAdr),
      .i_saveAdr                  (i_saveAdr),
      .i_saveData                 (i_saveData),
      .i_saveMask                 (i_saveMask),
      .o_pausePipeline            (o_pausePipeline),
      .o_flushClearMask           (o_flushClearMask),
      .o_memReq                   (o_memReq),
      .o_memWrite                 (o_memWrite),
      .o_memAdr                   (o_memAdr),
      .o_memMask                  (o_memMask),
      .o_memWriteData             (o_memWriteData),
      .i_memAck                   (i_memAck),
      .i_memReadValid             (i_memReadValid),
      .i_memReadData              (i_memReadData),
      .o_importBGBlockSingleClock (o_importBGBlockSingleClock),
      .o_importedBGBlock          (o_importedBGBlock),
      .o_busy                     (o_busy),
      .o_error                    (o_error)
   );

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) begin
         r[32*k +: 32] = $urandom;
      end
      return r;
   endfunction

   function automatic VectorRec mkVec(input int kind, input logic need, input logic [15:0] mask,
                                      input logic [14:0] saveAdr, input logic [14:0] loadAdr,
                                      input int ackDelay, input int readDelay, input int ew,
                                      input int el, input int ei, input int ef, input int ep);
      VectorRec v;
      v.kind = kind; v.need = need; v.mask = mask; v.saveAdr = saveAdr; v.loadAdr = loadAdr;
      v.ackDelay = ackDelay; v.readDelay = readDelay;
      v.expWrites = ew; v.expLoads = el; v.expImports = ei; v.expFlushes = ef; v.expPause = ep;
      return v;
   endfunction

   // Reference: count transactions and stalled cycles straight from the sequencing rules.
   function automatic VectorRec modelVector(input VectorRec v);
      VectorRec r;
      int isEnd;
      int isDone;
      r = v;
      isEnd  = (v.kind >= 2) ? 1 : 0;
      isDone = (v.kind == 1) ? 1 : 0;
      r.expWrites  = ((isEnd || isDone) && v.mask != 0) ? 1 : 0;
      r.expLoads   = (!isEnd && v.need) ? 1 : 0;
      r.expImports = r.expLoads;
      r.expFlushes = isEnd;
      r.expPause   = 0;
      if (r.expWrites + r.expLoads + r.expFlushes > 0) begin
         r.expPause = 1 + r.expWrites * (v.ackDelay + 1)
                        + r.expLoads * ((v.ackDelay + 1) + (v.readDelay + 1) + 1)
                        + r.expFlushes;
      end
      return r;
   endfunction

   task automatic resetDut();
      i_rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic clearInputs();
      i_startPrimitive = 1'b0; i_blockDone = 1'b0; i_endPrimitive = 1'b0;
      i_needBGRead = 1'b0; i_loadAdr = '0; i_saveAdr = '0; i_saveData = '0; i_saveMask = '0;
      i_memAck = 1'b0; i_memReadValid = 1'b0; i_memReadData = '0;
   endtask

   // Drive one trigger, act as the memory, and tally what the scheduler did.
   task automatic applyStimulus(input VectorRec v, input int idx);
      logic [255:0] saveData;
      logic [255:0] readData;
      logic [255:0] gotImport;
      logic [255:0] heldData;
      logic [14:0]  heldAdr;
      logic [15:0]  heldMask;
      logic         heldWrite;
      int writes, loads, imports, flushes, pauseCycles, unstable, badFields;
      int reqAge, rdAt, saveAckCyc, readCyc, importCyc, flushCyc, writeCyc, loadCyc;
      bit finished;
      saveData = rand256();
      readData = rand256();
      gotImport = '0; heldData = '0; heldAdr = '0; heldMask = '0; heldWrite = 1'b0;
      writes = 0; loads = 0; imports = 0; flushes = 0; pauseCycles = 0; unstable = 0; badFields = 0;
      reqAge = 0; rdAt = -1; saveAckCyc = -1; readCyc = -1; importCyc = -1; flushCyc = -1;
      writeCyc = -1; loadCyc = -1; finished = 1'b0;

      @(posedge clk);
      #1;
      i_startPrimitive = (v.kind == 0);
      i_blockDone      = (v.kind == 1 || v.kind == 3);
      i_endPrimitive   = (v.kind >= 2);
      i_needBGRead     = v.need;
      i_loadAdr        = v.loadAdr;
      i_saveAdr        = v.saveAdr;
      i_saveData       = saveData;
      i_saveMask       = v.mask;
      #1;
      if (o_pausePipeline) pauseCycles++;

      for (int cyc = 1; cyc <= 80 && !finished; cyc++) begin
         @(posedge clk);
         #1;
         i_startPrimitive = 1'b0; i_blockDone = 1'b0; i_endPrimitive = 1'b0;
         i_needBGRead = ~v.need; i_loadAdr = ~v.loadAdr; i_saveAdr = ~v.saveAdr;
         i_saveData = ~saveData; i_saveMask = ~v.mask;
         i_memAck = 1'b0; i_memReadValid = 1'b0;
         if (o_memReq) begin
            reqAge++;
            if (reqAge == 1) begin
               heldWrite = o_memWrite; heldAdr = o_memAdr; heldMask = o_memMask; heldData = o_memWriteData;
               if (o_memWrite) begin
                  writes++; writeCyc = cyc;
                  if (o_memAdr !== v.saveAdr || o_memMask !== v.mask || o_memWriteData !== saveData) badFields++;
               end else begin
                  loads++; loadCyc = cyc;
                  if (o_memAdr !== v.loadAdr || o_memMask !== 16'h0) badFields++;
               end
            end else if ({o_memWrite, o_memAdr, o_memMask, o_memWriteData} !== {heldWrite, heldAdr, heldMask, heldData}) begin
               unstable++;
            end
            if (reqAge == v.ackDelay + 1) begin
               i_memAck = 1'b1;
               reqAge = 0;
               if (heldWrite) saveAckCyc = cyc;
               else rdAt = cyc + 1 + v.readDelay;
            end
         end
         if (cyc == rdAt) begin
            i_memReadValid = 1'b1;
            i_memReadData  = readData;
            readCyc = cyc;
         end
         #1;
         if (o_pausePipeline) pauseCycles++;
         if (o_importBGBlockSingleClock) begin
            imports++; importCyc = cyc; gotImport = o_importedBGBlock;
         end
         if (o_flushClearMask) begin
            flushes++; flushCyc = cyc;
         end
         if (!o_busy && !o_pausePipeline && !i_memAck && !i_memReadValid) finished = 1'b1;
      end
      i_memAck = 1'b0;
      i_memReadValid = 1'b0;

      checkOutput($sformatf("v%0d.finished", idx), finished, 1);
      checkOutput($sformatf("v%0d.writes", idx), writes, v.expWrites);
      checkOutput($sformatf("v%0d.loads", idx), loads, v.expLoads);
      checkOutput($sformatf("v%0d.imports", idx), imports, v.expImports);
      checkOutput($sformatf("v%0d.flushes", idx), flushes, v.expFlushes);
      checkOutput($sformatf("v%0d.pauseCycles", idx), pauseCycles, v.expPause);
      checkOutput($sformatf("v%0d.cmdFields", idx), badFields, 0);
      checkOutput($sformatf("v%0d.cmdStable", idx), unstable, 0);
      checkOutput($sformatf("v%0d.error", idx), o_error, 1'b0);
      if (imports > 0) begin
         checkOutput($sformatf("v%0d.importData", idx), gotImport, readData);
         checkOutput($sformatf("v%0d.importCycle", idx), importCyc, readCyc + 1);
      end
      if (writes > 0 && loads > 0) begin
         checkOutput($sformatf("v%0d.saveBeforeLoad", idx), writeCyc < loadCyc, 1'b1);
      end
      if (flushes > 0 && writes > 0) begin
         checkOutput($sformatf("v%0d.flushCycle", idx), flushCyc, saveAckCyc + 1);
      end
   endtask

   VectorRec table_[10];
   VectorRec rv;
   logic [255:0] pattern1;
   logic [255:0] pattern2;

   initial begin
      clearInputs();
      i_rst = 1'b1;

      table_[0] = mkVec(1, 1'b1, 16'h0005, 15'h0123, 15'h0124, 0, 1, 1, 1, 1, 0, 6);
      table_[1] = mkVec(1, 1'b0, 16'h0000, 15'h0200, 15'h0201, 0, 0, 0, 0, 0, 0, 0);
      table_[2] = mkVec(1, 1'b1, 16'h0000, 15'h0300, 15'h0301, 0, 0, 0, 1, 1, 0, 4);
      table_[3] = mkVec(2, 1'b0, 16'h8000, 15'h0400, 15'h0000, 3, 0, 1, 0, 0, 1, 6);
      table_[4] = mkVec(0, 1'b1, 16'h0000, 15'h0000, 15'h7FFF, 0, 0, 0, 1, 1, 0, 4);
      table_[5] = mkVec(0, 1'b0, 16'h0000, 15'h0000, 15'h0555, 0, 0, 0, 0, 0, 0, 0);
      table_[6] = mkVec(1, 1'b1, 16'h0005, 15'h0600, 15'h0601, 0, 0, 1, 1, 1, 0, 5);
      table_[7] = mkVec(2, 1'b1, 16'h0000, 15'h0700, 15'h0701, 0, 0, 0, 0, 0, 1, 2);
      table_[8] = mkVec(3, 1'b1, 16'hFFFF, 15'h0800, 15'h0801, 1, 0, 1, 0, 0, 1, 4);
      table_[9] = mkVec(1, 1'b0, 16'h0001, 15'h0900, 15'h0901, 2, 0, 1, 0, 0, 0, 4);

      // Outputs while held in reset
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("resetCtrl", {o_pausePipeline, o_flushClearMask, o_memReq, o_memWrite, o_memAdr,
                  o_memMask, o_importBGBlockSingleClock, o_busy, o_error}, '0);
      checkOutput("resetImported", o_importedBGBlock, '0);
      i_rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(table_[i], i);
      end

      // Reset while a load is outstanding in LOAD_WAIT
      @(posedge clk);
      #1;
      i_startPrimitive = 1'b1; i_needBGRead = 1'b1; i_loadAdr = 15'h0042;
      @(posedge clk);
      #1;
      i_startPrimitive = 1'b0;
      checkOutput("rstSeq.loadReq", {o_memReq, o_memWrite, o_memAdr}, {1'b1, 1'b0, 15'h0042});
      i_memAck = 1'b1;
      @(posedge clk);
      #1;
      i_memAck = 1'b0;
      checkOutput("rstSeq.waiting", {o_busy, o_memReq}, 2'b10);
      i_rst = 1'b1;
      #1;
      checkOutput("rstSeq.ctrlZero", {o_pausePipeline, o_flushClearMask, o_memReq, o_memWrite, o_memAdr,
                  o_memMask, o_importBGBlockSingleClock, o_busy, o_error}, '0);
      checkOutput("rstSeq.importedZero", o_importedBGBlock, '0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(posedge clk);
      #1;
      i_memReadValid = 1'b1; i_memReadData = rand256();
      @(posedge clk);
      #1;
      i_memReadValid = 1'b0;
      checkOutput("rstSeq.noImport", {o_importBGBlockSingleClock, o_busy}, 2'b00);
      checkOutput("rstSeq.importedStill", o_importedBGBlock, '0);
      checkOutput("rstSeq.lateReadError", o_error, 1'b1);
      resetDut();
      checkOutput("rstSeq.errorCleared", o_error, 1'b0);

      // Block done while a load request is pending, then a spurious read in IDLE
      pattern1 = rand256();
      pattern2 = ~pattern1;
      @(posedge clk);
      #1;
      i_startPrimitive = 1'b1; i_needBGRead = 1'b1; i_loadAdr = 15'h1111;
      @(posedge clk);
      #1;
      i_startPrimitive = 1'b0;
      i_blockDone = 1'b1; i_saveMask = 16'h00FF; i_saveAdr = 15'h3333; i_loadAdr = 15'h2222;
      @(posedge clk);
      #1;
      i_blockDone = 1'b0; i_saveMask = '0;
      checkOutput("proto.doneError", o_error, 1'b1);
      checkOutput("proto.doneIgnored", {o_memReq, o_memWrite, o_memAdr}, {1'b1, 1'b0, 15'h1111});
      i_memAck = 1'b1;
      @(posedge clk);
      #1;
      i_memAck = 1'b0;
      i_memReadValid = 1'b1; i_memReadData = pattern1;
      @(posedge clk);
      #1;
      i_memReadValid = 1'b0;
      checkOutput("proto.import", o_importBGBlockSingleClock, 1'b1);
      checkOutput("proto.importData", o_importedBGBlock, pattern1);
      @(posedge clk);
      #1;
      checkOutput("proto.idleAfter", {o_busy, o_memReq, o_pausePipeline}, 3'b000);
      checkOutput("proto.errorSticky", o_error, 1'b1);
      i_memReadValid = 1'b1; i_memReadData = pattern2;
      @(posedge clk);
      #1;
      i_memReadValid = 1'b0;
      checkOutput("proto.spuriousNoImport", o_importBGBlockSingleClock, 1'b0);
      checkOutput("proto.spuriousKept", o_importedBGBlock, pattern1);
      checkOutput("proto.spuriousError", o_error, 1'b1);
      resetDut();
      checkOutput("proto.errorCleared", o_error, 1'b0);

      // Randomized scenarios against the reference model
      for (int i = 0; i < 40; i++) begin
         rv.kind      = int'($urandom_range(0, 3));
         rv.need      = 1'($urandom_range(0, 1));
         rv.mask      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         rv.saveAdr   = 15'($urandom);
         rv.loadAdr   = 15'($urandom);
         rv.ackDelay  = int'($urandom_range(0, 3));
         rv.readDelay = int'($urandom_range(0, 3));
         rv = modelVector(rv);
         applyStimulus(rv, 100 + i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
